// File: rtl/hack_mem_arbiter.sv
// Hack data-RAM arbiter: CPU data port vs. screen-refresh DMA reader.
// Optional HACK_ARB_STATS_EN adds saturating stall / DMA-beat counters.
module hack_mem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int DMA_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef HACK_ARB_STATS_EN
  ,
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_dma_beats
`endif
);

  localparam int BW = $clog2(DMA_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(DMA_BURST);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    S_ARB,
    S_BURST
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_rv_q, cpu_rv_d;
  logic          dma_rv_q, dma_rv_d;
  logic          cpu_g, dma_g;
  logic          cpu_gnt;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    cpu_g    = 1'b0;
    dma_g    = 1'b0;
    unique case (state_q)
      S_ARB: begin
        if (dma_req && starve_q == STARVE_MAX) begin
          dma_g    = 1'b1;
          state_d  = S_BURST;
          beat_d   = BW'(1);
          starve_d = '0;
        end else if (cpu_req) begin
          cpu_g = 1'b1;
          if (!dma_req)
            starve_d = '0;
          else if (starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);
        end else if (dma_req) begin
          dma_g    = 1'b1;
          state_d  = S_BURST;
          beat_d   = BW'(1);
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      S_BURST: begin
        starve_d = '0;
        if (dma_req && beat_q < BURST_MAX) begin
          dma_g  = 1'b1;
          beat_d = beat_q + BW'(1);
        end else begin
          cpu_g   = cpu_req;
          state_d = S_ARB;
          beat_d  = '0;
        end
      end
      default: begin
        state_d  = S_ARB;
        beat_d   = '0;
        starve_d = '0;
      end
    endcase
  end

  // Held reset forces every output quiet, even with requests pending.
  assign cpu_gnt   = cpu_g & reset_n;
  assign dma_gnt   = dma_g & reset_n;
  assign cpu_stall = cpu_req & ~cpu_g & reset_n;

  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr :
                     dma_gnt ? dma_addr : '0;
  assign mem_wdata = mem_we ? cpu_wdata : '0;

  assign cpu_rv_d = cpu_gnt & ~cpu_we;
  assign dma_rv_d = dma_gnt;

  assign cpu_rvalid = cpu_rv_q;
  assign dma_rvalid = dma_rv_q;
  assign cpu_rdata  = cpu_rv_q ? mem_rdata : '0;
  assign dma_rdata  = dma_rv_q ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_ARB;
      beat_q   <= '0;
      starve_q <= '0;
      cpu_rv_q <= 1'b0;
      dma_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
      cpu_rv_q <= cpu_rv_d;
      dma_rv_q <= dma_rv_d;
    end
  end

`ifdef HACK_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] beats_q, beats_d;

  always_comb begin
    stall_d = stall_q;
    beats_d = beats_q;
    if (cpu_stall && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
    if (dma_gnt && beats_q != 16'hFFFF)
      beats_d = beats_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_d;
      beats_q <= beats_d;
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_dma_beats = beats_q;
`endif

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Bench for hack_mem_arbiter: RAM model, cycle-level arbitration model
// checked every negedge, plus literal expectations for directed scenarios.
module tb_hack_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int BURST = 4;
  localparam int LIMIT = 8;

  logic          clk;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef HACK_ARB_STATS_EN
  logic [15:0]   stat_stall_cnt, stat_dma_beats;
`endif

  hack_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .DMA_BURST(BURST), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef HACK_ARB_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_dma_beats(stat_dma_beats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {1'b0, a} ^ 16'h5A5A;
  endfunction

  // RAM with one-cycle read latency
  logic [DW-1:0] ram [0:32767];
  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = init_val(AW'(i));
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: burst beats taken, DMA cycles denied, shadow memory
  logic [DW-1:0] shadow [int];
  int  m_beats = 0;
  int  m_denied = 0;
  bit  p_cpu = 0, p_dma = 0;
  logic [DW-1:0] e_cpu = '0, e_dma = '0;
  int  m_stalls = 0, m_dbeats = 0;

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  always @(negedge clk) begin
    int g;
    if (!reset_n) begin
      chk("rst_mem_en", mem_en, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_rvalids", {cpu_rvalid, dma_rvalid}, 0);
      chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
`ifdef HACK_ARB_STATS_EN
      chk("rst_stats", {stat_stall_cnt, stat_dma_beats}, 0);
`endif
      m_beats = 0; m_denied = 0;
      p_cpu = 0; p_dma = 0;
      m_stalls = 0; m_dbeats = 0;
    end else begin
      // g: 0 none, 1 CPU, 2 DMA
      g = 0;
      if (m_beats == 0) begin
        if (dma_req && m_denied >= LIMIT) g = 2;
        else if (cpu_req) g = 1;
        else if (dma_req) g = 2;
      end else begin
        if (dma_req && m_beats < BURST) g = 2;
        else if (cpu_req) g = 1;
      end
      chk("cpu_stall", cpu_stall, (cpu_req && g != 1));
      chk("dma_gnt", dma_gnt, (g == 2));
      chk("mem_en", mem_en, (g != 0));
      chk("mem_we", mem_we, (g == 1 && cpu_we));
      if (g == 1) chk("mem_addr_cpu", mem_addr, cpu_addr);
      if (g == 1 && cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
      if (g == 2) chk("mem_addr_dma", mem_addr, dma_addr);
      chk("cpu_rvalid", cpu_rvalid, p_cpu);
      chk("cpu_rdata", cpu_rdata, p_cpu ? e_cpu : 16'h0);
      chk("dma_rvalid", dma_rvalid, p_dma);
      chk("dma_rdata", dma_rdata, p_dma ? e_dma : 16'h0);
`ifdef HACK_ARB_STATS_EN
      chk("stat_stall", stat_stall_cnt, m_stalls);
      chk("stat_beats", stat_dma_beats, m_dbeats);
      if (cpu_req && g != 1 && m_stalls < 16'hFFFF) m_stalls++;
      if (g == 2 && m_dbeats < 16'hFFFF) m_dbeats++;
`endif
      p_cpu = (g == 1 && !cpu_we);
      p_dma = (g == 2);
      if (g == 1) e_cpu = expect_rd(cpu_addr);
      if (g == 2) e_dma = expect_rd(dma_addr);
      if (g == 1 && cpu_we) shadow[int'(cpu_addr)] = cpu_wdata;
      if (m_beats == 0) begin
        if (g == 2) begin m_beats = 1; m_denied = 0; end
        else if (g == 1) m_denied = dma_req ? ((m_denied < LIMIT) ? m_denied + 1 : LIMIT) : 0;
        else m_denied = 0;
      end else if (g == 2) begin
        m_beats++;
      end else begin
        m_beats = 0; m_denied = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; dma_req = 0;
  endtask

  task automatic pulse_reset();
    step();
    reset_n = 0;
    step();
    reset_n = 1;
  endtask

  logic [5:0] dpat;
  int first_dma, run_len, stalls, cpu_grants;

  initial begin
    reset_n = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_addr = '0;
    #2;
    chk("t0_mem_en", mem_en, 0);
    chk("t0_outs", {cpu_stall, dma_gnt, cpu_rvalid, dma_rvalid}, 0);
    cpu_req = 1; dma_req = 1;
    #1;
    chk("t0_req_forced", {cpu_stall, dma_gnt, mem_en}, 0);
    idle();
    step();
    step();
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("idle_mem_en", mem_en, 0);
      step();
    end

    // CPU write then read-back
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0010; cpu_wdata = 16'h1234;
    #2;
    chk("wr_mem_we", mem_we, 1);
    chk("wr_stall", cpu_stall, 0);
    step();
    cpu_we = 0;
    #2;
    chk("rd_mem_en_we", {mem_en, mem_we}, 2'b10);
    chk("rd_stall", cpu_stall, 0);
    step();
    idle();
    #2;
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata", cpu_rdata, 16'h1234);
    step();
    step();

    // DMA only for 6 cycles
    dma_req = 1;
    for (int i = 0; i < 6; i++) begin
      dma_addr = AW'(15'h4000 + i);
      #2;
      dpat[i] = dma_gnt;
      step();
    end
    idle();
    #2;
    chk("dma_pattern", dpat, 6'b101111);
    chk("dma_last_rvalid", dma_rvalid, 1);
    chk("dma_last_rdata", dma_rdata, 16'h1A5F);
    step();

    // Continuous contention from a clean reset
    pulse_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0020;
    dma_req = 1; dma_addr = 15'h0030;
    first_dma = -1; run_len = 0; stalls = 0; cpu_grants = 0;
    for (int i = 0; i < 24; i++) begin
      #2;
      if (i < 12) stalls += int'(cpu_stall);
      if (i < 8) cpu_grants += int'(mem_en && !dma_gnt);
      if (dma_gnt && first_dma < 0) first_dma = i;
      if (first_dma >= 0 && i < first_dma + 6 && dma_gnt && run_len == i - first_dma)
        run_len++;
      step();
    end
    idle();
    chk("cont_cpu_first8", cpu_grants, 8);
    chk("cont_first_dma", first_dma, 8);
    chk("cont_dma_run", run_len, 4);
    chk("cont_stalls", stalls, 4);
    step();

    // Reset in the middle of a DMA burst
    pulse_reset();
    dma_req = 1; dma_addr = 15'h0100;
    step();
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0040;
    #1;
    chk("mid_pre_dma_gnt", dma_gnt, 1);
    reset_n = 0;
    #1;
    chk("mid_rst_outs", {dma_gnt, cpu_stall, mem_en, mem_we}, 0);
    chk("mid_rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
    chk("mid_rst_rdata", {cpu_rdata, dma_rdata}, 0);
    step();
    reset_n = 1;
    #2;
    chk("post_cpu_gnt", {mem_en, dma_gnt, cpu_stall}, 3'b100);
    chk("post_addr", mem_addr, 15'h0040);
    chk("post_no_dma_rv", dma_rvalid, 0);
    step();
    idle();
    #2;
    chk("post_cpu_rvalid", cpu_rvalid, 1);
    chk("post_cpu_rdata", cpu_rdata, 16'h5A1A);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
